// File: rtl/chiplib_pri_queue_ingress.sv
// chiplib_pri_queue_ingress
// Merges NumSources ready/valid producers into the priority queue push port
// using round-robin arbitration, with the winner held in a one-entry output
// register so downstream timing is fully decoupled from the sources.
// Optional feature: define CHIPLIB_PRI_QUEUE_INGRESS_AGING_EN to give every
// source a saturating wait counter whose shifted value is added to the
// captured priority (arbitration order is unaffected by aging).
module chiplib_pri_queue_ingress #(
    parameter int NumSources    = 4,
    parameter int DataWidth     = 64,
    parameter int PriorityWidth = 16,
    parameter int AgeWidth      = 8,
    parameter int AgeShift      = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NumSources*DataWidth-1:0]     src_data,
    input  logic [NumSources*PriorityWidth-1:0] src_pri,
    input  logic [NumSources-1:0]               src_valid,
    output logic [NumSources-1:0]               src_ready,
    output logic [DataWidth-1:0]                push_data,
    output logic [PriorityWidth-1:0]            push_pri,
    output logic [$clog2(NumSources)-1:0]       push_src,
    output logic                                push_valid,
    input  logic                                push_ready
);

    localparam int IdxW = $clog2(NumSources);

    // Reject configurations the arbiter and aging math are not built for.
    if (NumSources < 2 || AgeWidth < 1 || AgeShift < 0) begin : g_bad_cfg
        $error("chiplib_pri_queue_ingress: unsupported parameter set");
    end

    // Output slot state
    logic                     push_valid_q, push_valid_d;
    logic [DataWidth-1:0]     push_data_q, push_data_d;
    logic [PriorityWidth-1:0] push_pri_q, push_pri_d;
    logic [IdxW-1:0]          push_src_q, push_src_d;
    logic [IdxW-1:0]          rr_ptr_q, rr_ptr_d;

    // Arbitration
    logic                     load_en;
    logic                     grant_found;
    logic [IdxW-1:0]          grant_idx;
    logic [NumSources-1:0]    grant;
    logic                     handshake;
    int                       cand;
    logic [IdxW-1:0]          cand_idx;

    // Per-source unpacked views
    logic [DataWidth-1:0]     data_arr [NumSources];
    logic [PriorityWidth-1:0] pri_eff  [NumSources];

`ifdef CHIPLIB_PRI_QUEUE_INGRESS_AGING_EN
    // Wide enough that neither the priority nor the shifted age can overflow.
    localparam int SumW = ((PriorityWidth > AgeWidth) ? PriorityWidth : AgeWidth) + 1;
`endif

    for (genvar gi = 0; gi < NumSources; gi++) begin : g_src
        logic [PriorityWidth-1:0] pri_raw;

        assign data_arr[gi] = src_data[gi*DataWidth +: DataWidth];
        assign pri_raw      = src_pri[gi*PriorityWidth +: PriorityWidth];

`ifdef CHIPLIB_PRI_QUEUE_INGRESS_AGING_EN
        logic [AgeWidth-1:0] age_q, age_d;
        logic [SumW-1:0]     pri_sum;

        // Wait counter: clear when accepted, saturate while stalled, hold when idle.
        always_comb begin
            age_d = age_q;
            if (src_valid[gi] && src_ready[gi]) begin
                age_d = '0;
            end else if (src_valid[gi] && !(&age_q)) begin
                age_d = age_q + 1'b1;
            end
        end

        // Wait counter register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                age_q <= '0;
            end else begin
                age_q <= age_d;
            end
        end

        assign pri_sum     = SumW'(pri_raw) + SumW'(age_q >> AgeShift);
        assign pri_eff[gi] = (pri_sum > SumW'({PriorityWidth{1'b1}})) ?
                             {PriorityWidth{1'b1}} : pri_sum[PriorityWidth-1:0];
`else
        assign pri_eff[gi] = pri_raw;
`endif
    end

    assign load_en = !push_valid_q || push_ready;

    // Round-robin search: first valid source at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NumSources; k++) begin
            cand     = (int'(rr_ptr_q) + k) % NumSources;
            cand_idx = IdxW'(cand);
            if (!grant_found && src_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign grant     = grant_found ? (NumSources'(1) << grant_idx) : '0;
    assign src_ready = grant & {NumSources{load_en & rst_n}};
    assign handshake = grant_found && load_en;

    // Slot and pointer next state: load on handshake, drain on pop.
    always_comb begin
        push_valid_d = push_valid_q;
        push_data_d  = push_data_q;
        push_pri_d   = push_pri_q;
        push_src_d   = push_src_q;
        rr_ptr_d     = rr_ptr_q;
        if (load_en) begin
            push_valid_d = handshake;
            if (handshake) begin
                push_data_d = data_arr[grant_idx];
                push_pri_d  = pri_eff[grant_idx];
                push_src_d  = grant_idx;
                rr_ptr_d    = (grant_idx == IdxW'(NumSources - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Slot and pointer registers; reset drops any held item immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_valid_q <= 1'b0;
            push_data_q  <= '0;
            push_pri_q   <= '0;
            push_src_q   <= '0;
            rr_ptr_q     <= '0;
        end else begin
            push_valid_q <= push_valid_d;
            push_data_q  <= push_data_d;
            push_pri_q   <= push_pri_d;
            push_src_q   <= push_src_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign push_valid = push_valid_q;
    assign push_data  = push_data_q;
    assign push_pri   = push_pri_q;
    assign push_src   = push_src_q;

endmodule

// File: doc/chiplib_pri_queue_ingress.md
# chiplib_pri_queue_ingress

Multi-source ingress stage that sits directly upstream of the priority queue's push port. Merges `NumSources` independent ready/valid producers into the single push stream with round-robin arbitration. The winner is captured in a one-entry output register, so downstream timing is decoupled and throughput stays at one item per cycle. Optional per-source aging raises the priority of items that have waited, bounding starvation of low-priority producers.

## Interface
Parameters:
- `NumSources`, 4, number of producer ports (≥2)
- `DataWidth`, 64, payload width
- `PriorityWidth`, 16, priority width; numerically larger = higher priority
- `AgeWidth`, 8, per-source wait counter width (used only with aging)
- `AgeShift`, 2, right-shift applied to wait count before adding to priority

Ports:
- `clk`  in  1  clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset
- `src_data`  in  NumSources*DataWidth  payload, source i at slice i
- `src_pri`  in  NumSources*PriorityWidth  priority, source i at slice i
- `src_valid`  in  NumSources  per-source valid
- `src_ready`  out  NumSources  per-source ready (one-hot or zero)
- `push_data`  out  DataWidth  registered payload to queue
- `push_pri`  out  PriorityWidth  registered (possibly aged) priority
- `push_src`  out  $clog2(NumSources)  index of source that produced the item
- `push_valid`  out  1  output slot occupied
- `push_ready`  in  1  queue accepts (not full)

## Operation
- Output slot: one register holding data/pri/src plus `push_valid`.
- `load_en` = !push_valid || push_ready.
- Arbiter: round-robin over `src_valid`, searching from `rr_ptr` upward with wrap. `grant` is one-hot of the first valid source found.
- `src_ready[i]` = grant[i] && load_en && rst_n. It is combinational from `push_ready`, and it is 0 whenever `rst_n` is low.
- Source handshake on `src_valid[i] && src_ready[i]`:
  - slot loads source i's data, priority and index
  - `push_valid` set
  - `rr_ptr` ← (i+1) mod NumSources
- Output handshake on `push_valid && push_ready`:
  - if no source handshakes in the same cycle, `push_valid` clears
  - simultaneous pop and load keeps `push_valid` = 1 with new contents
- `push_data`, `push_pri` and `push_src` are stable while `push_valid && !push_ready`.
- No valid sources: `rr_ptr` holds and no grant is issued.
- `rr_ptr` wrap: from NumSources-1 it advances to 0. For non-power-of-two NumSources it never holds an out-of-range value.
- Reset is asynchronous. Mid-operation it drops the slot contents. Every state element returns to its reset value immediately.

## Timing
- Reset values:
  - `push_valid`=0, `push_data`=0, `push_pri`=0, `push_src`=0
  - `rr_ptr`=0, all age counters 0
  - `src_ready`=0
- Latency: 1 cycle from source handshake to `push_valid`.
- Throughput: 1 item/cycle while `push_ready` is held high.
- No combinational path from `src_*` inputs to `push_*` outputs.

## Configuration
- Macro: `CHIPLIB_PRI_QUEUE_INGRESS_AGING_EN`.
- Defined:
  - each source keeps `age[i]` (AgeWidth bits)
  - `age[i]` increments, saturating at all-ones, each cycle `src_valid[i] && !src_ready[i]`
  - `age[i]` clears to 0 on source i's handshake and holds when `src_valid[i]` is low
  - captured priority = min(src_pri[i] + (age[i] >> AgeShift), 2^PriorityWidth−1), computed in PriorityWidth+1 bits and saturated
  - aging does not alter arbitration order
- Undefined: no age counters are instantiated, and captured priority equals `src_pri[i]` unchanged.

## Test plan
- Reset, then idle: all four sources valid, `push_ready`=1 → one item per cycle, `push_src` sequence 0,1,2,3,0,…; first `push_valid` one cycle after the first handshake.
- Backpressure: `push_ready`=0 with slot full and data=0xAA from src 2 → `push_data` holds 0xAA, all `src_ready`=0; `push_ready`=1 → next source (3) is granted in that cycle.
- Sparse: only src 1 valid after `rr_ptr`=3 → search wraps, src 1 is granted, `rr_ptr` becomes 2.
- Async reset asserted mid-stream with `push_valid`=1 → `push_valid`=0 and `src_ready`=0 immediately; after release the first grant goes to src 0.
- Aging (macro on, AgeShift=2): src 3 with pri=0xFFFE is blocked 12 cycles → captured `push_pri`=0xFFFF (saturated). src 0 with pri=5 blocked 8 cycles → `push_pri`=7.
- Aging off: same stimulus → `push_pri` equals the raw priorities 0xFFFE and 5.
